// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: a CPU write to $4014 halts the CPU and copies one page into OAMDATA.
// Optional macro OAM_DMA_PARITY_ALIGN_EN adds the ALIGN state and parity flop.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAMDATA_REG  = 3'd4,
  parameter int          XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_WE,
  output logic        cpu_halt,
  output logic [15:0] dma_mem_addr,
  output logic        dma_mem_rd,
  input  logic [7:0]  dma_mem_data,
  output logic        ppu_cs_n,
  output logic [2:0]  ppu_reg_addr,
  output logic        ppu_WE,
  output logic [7:0]  ppu_data,
  output logic        dma_busy,
  output logic        dma_done
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    READ,
    WRITE
`ifdef OAM_DMA_PARITY_ALIGN_EN
    , ALIGN
`endif
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [15:0] addr_hold;
  logic [2:0]  reg_hold;
  logic [7:0]  data_hold;
  logic        done_q;
  logic        trigger;
  logic        last_byte;

  assign trigger   = cpu_WE && (cpu_addr == DMA_REG_ADDR);
  assign last_byte = (idx == LAST_IDX);
  assign dma_done  = done_q;

`ifdef OAM_DMA_PARITY_ALIGN_EN
  // Free-running CPU cycle parity; reads must start on an even cycle.
  logic parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity <= 1'b0;
    else        parity <= ~parity;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Page/index bookkeeping plus the registers that let bus outputs hold their last values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      page      <= 8'h00;
      idx       <= 8'h00;
      addr_hold <= 16'h0000;
      reg_hold  <= 3'd0;
      data_hold <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == WRITE) && last_byte;
      if ((state == IDLE) && trigger) begin
        page <= cpu_data_in;
        idx  <= 8'h00;
      end
      if (state == READ) addr_hold <= {page, idx};
      if (state == WRITE) begin
        idx       <= idx + 8'd1;
        reg_hold  <= OAMDATA_REG;
        data_hold <= dma_mem_data;
      end
    end
  end

  always_comb begin
    state_next   = state;
    cpu_halt     = 1'b0;
    dma_busy     = 1'b0;
    dma_mem_rd   = 1'b0;
    dma_mem_addr = addr_hold;
    ppu_cs_n     = 1'b1;
    ppu_reg_addr = reg_hold;
    ppu_WE       = 1'b0;
    ppu_data     = data_hold;
    case (state)
      IDLE: begin
        if (trigger) state_next = HALT;
      end
      HALT: begin
        cpu_halt = 1'b1;
        dma_busy = 1'b1;
`ifdef OAM_DMA_PARITY_ALIGN_EN
        state_next = parity ? READ : ALIGN;
`else
        state_next = READ;
`endif
      end
`ifdef OAM_DMA_PARITY_ALIGN_EN
      ALIGN: begin
        cpu_halt   = 1'b1;
        dma_busy   = 1'b1;
        state_next = READ;
      end
`endif
      READ: begin
        cpu_halt     = 1'b1;
        dma_busy     = 1'b1;
        dma_mem_rd   = 1'b1;
        dma_mem_addr = {page, idx};
        state_next   = WRITE;
      end
      WRITE: begin
        cpu_halt     = 1'b1;
        dma_busy     = 1'b1;
        ppu_cs_n     = 1'b0;
        ppu_reg_addr = OAMDATA_REG;
        ppu_WE       = 1'b1;
        ppu_data     = dma_mem_data;
        state_next   = last_byte ? IDLE : READ;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
